decode_queue: RTL and testbench
===============================

DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 Parameter DEPTH, 4, number of instruction entries; power of two, minimum 2.
REQ-002 Parameter XLEN, 32, width of pc, instr and etval fields.
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset; sampled on rising edge of clock.
REQ-005 f_valid  in  1  fetch presents an entry this cycle.
REQ-006 f_pc, f_instr, f_etval  in  XLEN each  fetch entry payload.
REQ-007 f_exception  in  1, f_ecause  in  4  fetch-side exception flag and cause.
REQ-008 f_ready  out  1  queue accepts an entry this cycle.
REQ-009 d_stall  in  1  decode stall; the head entry is held.
REQ-010 d_clear  in  1  pipeline flush (jump, exception, mret, execute clear).
REQ-011 d_valid  out  1  head entry is presented to decode.
REQ-012 d_pc, d_instr, d_npc, d_etval  out  XLEN each; d_exception out 1; d_ecause out 4  head payload.
REQ-013 count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-014 Storage is a circular buffer of DEPTH entries with write pointer, read pointer and count; both pointers wrap modulo DEPTH.
REQ-015 f_ready shall be 1 when count < DEPTH; it shall not depend on d_stall or on a pop in the same cycle.
REQ-016 Push occurs when f_valid=1, f_ready=1 and d_clear=0.
REQ-017 Pop occurs when d_valid=1, d_stall=0 and d_clear=0.
REQ-018 Push and pop in the same cycle leave count unchanged and advance both pointers.
REQ-019 d_valid shall be 1 when count > 0; the outputs are the entry at the read pointer.
REQ-020 While d_stall=1, the outputs and the head entry shall remain stable.
REQ-021 d_npc shall equal d_pc+4 when d_instr[1:0]=2'b11, else d_pc+2, truncated to XLEN.
REQ-022 On d_clear=1, next-cycle count, write pointer and read pointer shall be 0; a same-cycle push is discarded.
REQ-023 d_clear has priority over d_stall, push and pop.
REQ-024 Entries with f_exception=1 are stored and presented unchanged; the queue does not interpret them.
REQ-025 When full (count=DEPTH), f_valid is ignored; no entry is overwritten.
REQ-026 When empty, and with the bypass feature disabled, d_valid=0 and the payload outputs are don't-care.

Reset
REQ-027 When reset=0 at a clock edge: count=0, both pointers=0, d_valid=0, f_ready=1 from the next cycle.
REQ-028 Reset during operation discards all entries; entry storage is not required to be cleared.
REQ-029 Reset has priority over d_clear and all other inputs.

Configuration
REQ-030 Macro DECODE_QUEUE_BYPASS_EN.
- Defined: when count=0, f_valid=1 and d_clear=0, d_valid=1 in the same cycle with the fetch payload passed combinationally.
- Defined: if additionally d_stall=0, the entry is consumed without being written and count stays 0.
- Defined: if d_stall=1, the entry is written and count becomes 1.
- Undefined: minimum latency from push to d_valid is one cycle; there is no combinational path from f_* to d_*.

Verification
REQ-031 Reset, then push 5 entries with DEPTH=4 and d_stall=1 -> f_ready=0 after 4 pushes, count=4, 5th entry dropped, d_pc holds the first pc.
REQ-032 Push pc=0x100 instr=0x00000013, then pc=0x104 instr=0x4501 -> d_npc=0x104 then 0x106, in order, with no bypass.
REQ-033 Full queue, d_clear=1 with f_valid=1 -> next cycle count=0, d_valid=0, f_ready=1; the pushed entry never appears.
REQ-034 Continuous push and pop with count=2 for 10 cycles across pointer wrap -> count stays 2 and the pc sequence is preserved with no gaps.
REQ-035 Entry with f_exception=1, f_ecause=1, f_etval=0x200 -> presented with identical fields; d_stall=1 for 3 cycles holds it stable.
REQ-036 DECODE_QUEUE_BYPASS_EN defined, empty queue, push pc=0x300 with d_stall=0 -> d_valid=1 and d_pc=0x300 in the same cycle, count stays 0; undefined -> d_valid=1 one cycle later.

Source files
------------

// File: rtl/decode_queue_if.sv
// decode_queue_if: fetch-side push and decode-side pop signals of the decode queue
interface decode_queue_if #(parameter int XLEN = 32);
  logic            f_valid;
  logic            f_ready;
  logic [XLEN-1:0] f_pc;
  logic [XLEN-1:0] f_instr;
  logic [XLEN-1:0] f_etval;
  logic            f_exception;
  logic [3:0]      f_ecause;
  logic            d_stall;
  logic            d_clear;
  logic            d_valid;
  logic [XLEN-1:0] d_pc;
  logic [XLEN-1:0] d_instr;
  logic [XLEN-1:0] d_npc;
  logic [XLEN-1:0] d_etval;
  logic            d_exception;
  logic [3:0]      d_ecause;
  modport master (
    output f_valid, f_pc, f_instr, f_etval, f_exception, f_ecause, d_stall, d_clear,
    input  f_ready, d_valid, d_pc, d_instr, d_npc, d_etval, d_exception, d_ecause
  );
  modport slave (
    input  f_valid, f_pc, f_instr, f_etval, f_exception, f_ecause, d_stall, d_clear,
    output f_ready, d_valid, d_pc, d_instr, d_npc, d_etval, d_exception, d_ecause
  );
endinterface

// File: rtl/decode_queue.sv
// decode_queue: circular fetch-to-decode instruction queue; DECODE_QUEUE_BYPASS_EN adds same-cycle bypass when empty
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  decode_queue_if.slave          bus,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] etval;
    logic            exception;
    logic [3:0]      ecause;
  } entry_t;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  entry_t        f_entry, head;
  logic          byp, push, pop, take, wr_en, rd_en;
  // handshake, head selection and next-state of pointers, count and storage
  always_comb begin
    f_entry = '{pc: bus.f_pc, instr: bus.f_instr, etval: bus.f_etval,
                exception: bus.f_exception, ecause: bus.f_ecause};
    bus.f_ready = count_q < CW'(DEPTH);
`ifdef DECODE_QUEUE_BYPASS_EN
    byp = (count_q == '0) && bus.f_valid && !bus.d_clear;
`else
    byp = 1'b0;
`endif
    head = byp ? f_entry : mem_q[rd_ptr_q];
    bus.d_valid = (count_q != '0) || byp;
    push = bus.f_valid && bus.f_ready && !bus.d_clear;
    pop = bus.d_valid && !bus.d_stall && !bus.d_clear;
    take = byp && pop;
    wr_en = push && !take;
    rd_en = pop && !take;
    bus.d_pc = head.pc;
    bus.d_instr = head.instr;
    bus.d_etval = head.etval;
    bus.d_exception = head.exception;
    bus.d_ecause = head.ecause;
    bus.d_npc = head.pc + ((head.instr[1:0] == 2'b11) ? XLEN'(4) : XLEN'(2));
    wr_ptr_d = bus.d_clear ? '0 : wr_ptr_q + AW'(wr_en);
    rd_ptr_d = bus.d_clear ? '0 : rd_ptr_q + AW'(rd_en);
    count_d = bus.d_clear ? '0 : count_q + CW'(wr_en) - CW'(rd_en);
    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = f_entry;
  end
  // pointer and occupancy state, cleared by reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  // entry storage, never reset since occupancy alone marks valid entries
  always_ff @(posedge clock) mem_q <= mem_d;
  assign count = count_q;
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: scoreboard bench for decode_queue with directed vectors
module tb_decode_queue;
  localparam int DEPTH = 4;
`ifdef DECODE_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] npc;
    logic [31:0] etval;
    logic        exc;
    logic [3:0]  ec;
  } ent_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [2:0] count;
  ent_t exp_q[$];
  ent_t h;
  logic exp_v;
  int mcount = 0;
  int errors = 0;
  int checks = 0;

  decode_queue_if #(.XLEN(32)) bus ();
  decode_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (.clock(clock), .reset(reset), .bus(bus), .count(count));

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                     input logic [31:0] npc, input logic [31:0] etval, input logic exc,
                     input logic [3:0] ec, input logic stall, input logic clr);
    logic byp, push, pop;
    ent_t e;
    bus.f_valid = v;
    bus.f_pc = pc;
    bus.f_instr = instr;
    bus.f_etval = etval;
    bus.f_exception = exc;
    bus.f_ecause = ec;
    bus.d_stall = stall;
    bus.d_clear = clr;
    byp = BYP && mcount == 0 && v && !clr;
    push = v && mcount < DEPTH && !clr;
    pop = (mcount > 0 || byp) && !stall && !clr;
    if (clr) exp_q.delete();
    if (push) begin
      e = '{pc, instr, npc, etval, exc, ec};
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
    mcount = clr ? 0 : mcount + int'(push) - int'(pop);
  endtask

  task automatic idle(input int n, input logic stall);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, '0, '0, 1'b0, 4'd0, stall, 1'b0);
  endtask

  always @(negedge clock) begin
    if (reset) begin
      exp_v = mcount > 0 || (BYP && mcount == 0 && bus.f_valid && !bus.d_clear);
      check("count", 64'(count), 64'(mcount));
      check("f_ready", 64'(bus.f_ready), 64'(mcount < DEPTH));
      check("d_valid", 64'(bus.d_valid), 64'(exp_v));
      if (bus.d_valid && !bus.d_clear) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_entry: got pc %0h expected no entry at %0t", bus.d_pc, $time);
        end else begin
          h = exp_q[0];
          check("d_pc", 64'(bus.d_pc), 64'(h.pc));
          check("d_instr", 64'(bus.d_instr), 64'(h.instr));
          check("d_npc", 64'(bus.d_npc), 64'(h.npc));
          check("d_etval", 64'(bus.d_etval), 64'(h.etval));
          check("d_exception", 64'(bus.d_exception), 64'(h.exc));
          check("d_ecause", 64'(bus.d_ecause), 64'(h.ec));
          if (!bus.d_stall) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bus.f_valid = 1'b0;
    bus.f_pc = '0;
    bus.f_instr = '0;
    bus.f_etval = '0;
    bus.f_exception = 1'b0;
    bus.f_ecause = '0;
    bus.d_stall = 1'b0;
    bus.d_clear = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("reset_count", 64'(count), 64'd0);
    check("reset_d_valid", 64'(bus.d_valid), 64'd0);
    check("reset_f_ready", 64'(bus.f_ready), 64'd1);
    @(posedge clock);
    #1;
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 32'h10 + 32'(4 * i), 32'h13, 32'h14 + 32'(4 * i), '0, 1'b0, 4'd0, 1'b1, 1'b0);
    check("full_count", 64'(count), 64'd4);
    check("full_f_ready", 64'(bus.f_ready), 64'd0);
    check("full_head_pc", 64'(bus.d_pc), 64'h10);
    idle(5, 1'b0);
    cyc(1'b1, 32'h100, 32'h0000_0013, 32'h104, '0, 1'b0, 4'd0, 1'b0, 1'b0);
    cyc(1'b1, 32'h104, 32'h0000_4501, 32'h106, '0, 1'b0, 4'd0, 1'b0, 1'b0);
    idle(2, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 32'h200 + 32'(4 * i), 32'h13, 32'h204 + 32'(4 * i), '0, 1'b0, 4'd0, 1'b1, 1'b0);
    cyc(1'b1, 32'h999, 32'h13, 32'h99d, '0, 1'b0, 4'd0, 1'b1, 1'b1);
    check("clear_count", 64'(count), 64'd0);
    check("clear_d_valid", 64'(bus.d_valid), 64'd0);
    check("clear_f_ready", 64'(bus.f_ready), 64'd1);
    idle(2, 1'b0);
    cyc(1'b1, 32'h500, 32'h13, 32'h504, '0, 1'b0, 4'd0, 1'b1, 1'b0);
    cyc(1'b1, 32'h504, 32'h13, 32'h508, '0, 1'b0, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 32'h508 + 32'(4 * i), 32'h13, 32'h50c + 32'(4 * i), '0, 1'b0, 4'd0, 1'b0, 1'b0);
    check("stream_count", 64'(count), 64'd2);
    idle(3, 1'b0);
    cyc(1'b1, 32'h400, 32'h73, 32'h404, 32'h200, 1'b1, 4'd1, 1'b1, 1'b0);
    idle(3, 1'b1);
    idle(2, 1'b0);
    cyc(1'b1, 32'h300, 32'h13, 32'h304, '0, 1'b0, 4'd0, 1'b0, 1'b0);
    idle(2, 1'b0);
    check("drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
